// File: rtl/nibble_serial_alu_if.sv
// rtl/nibble_serial_alu_if.sv - operation request/result bundle for the nibble-serial 181-style ALU
interface nibble_serial_alu_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       S;
    logic             M;
    logic             Cn;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] F;
    logic             Cn4;
    logic             AeqB;

    modport master (
        output start, A, B, S, M, Cn,
        input  busy, done, F, Cn4, AeqB
    );

    modport slave (
        input  start, A, B, S, M, Cn,
        output busy, done, F, Cn4, AeqB
    );
endinterface

// File: rtl/nibble_serial_alu.sv
// rtl/nibble_serial_alu.sv - 181-style ALU evaluated one nibble per clock, LSB first
module nibble_serial_alu #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    nibble_serial_alu_if.slave  bus
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       s_q;
    logic             m_q;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] acc;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       x_nib;
    logic [3:0]       y_nib;
    logic [4:0]       sum;
    logic [WIDTH-1:0] f_next;

    // One slice of the 181 datapath; f_next is the accumulated word with this slice merged in.
    always_comb begin
        a_nib  = a_q[{idx, 2'b00} +: 4];
        b_nib  = b_q[{idx, 2'b00} +: 4];
        x_nib  = a_nib | (b_nib & {4{s_q[0]}}) | (~b_nib & {4{s_q[1]}});
        y_nib  = (a_nib & ~b_nib & {4{s_q[2]}}) | (a_nib & b_nib & {4{s_q[3]}});
        if (m_q) begin
            sum = {1'b0, ~(x_nib ^ y_nib)};
        end else begin
            sum = {1'b0, x_nib} + {1'b0, y_nib} + {4'b0000, carry};
        end
        f_next = acc;
        f_next[{idx, 2'b00} +: 4] = sum[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.F    <= '0;
            bus.Cn4  <= 1'b1;
            bus.AeqB <= 1'b0;
            idx      <= '0;
            carry    <= 1'b0;
            acc      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            m_q      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_q      <= bus.A;
                        b_q      <= bus.B;
                        s_q      <= bus.S;
                        m_q      <= bus.M;
                        carry    <= ~bus.Cn;
                        idx      <= '0;
                        acc      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end else begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= f_next;
                    carry <= sum[4];
                    idx   <= idx + 1'b1;
                    // Visible results move only on the last slice so they never show a partial word.
                    if (idx == LAST) begin
                        bus.F    <= f_next;
                        bus.Cn4  <= m_q | ~sum[4];
                        bus.AeqB <= &f_next;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_alu.sv
// tb/tb_nibble_serial_alu.sv - scoreboard bench for nibble_serial_alu at WIDTH=16
module tb_nibble_serial_alu;
    typedef struct packed {
        logic [15:0] f;
        logic        cn4;
        logic        aeqb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests  = 0;
    int   failed = 0;
    exp_t sb[$];

    nibble_serial_alu_if #(.WIDTH(16)) bus ();

    nibble_serial_alu #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic [3:0] s, input logic m, input logic cn);
        logic [15:0] x;
        logic [15:0] y;
        logic [16:0] full;
        exp_t        e;
        x = a | (b & {16{s[0]}}) | (~b & {16{s[1]}});
        y = (a & ~b & {16{s[2]}}) | (a & b & {16{s[3]}});
        if (m) begin
            e.f   = ~(x ^ y);
            e.cn4 = 1'b1;
        end else begin
            full  = {1'b0, x} + {1'b0, y} + {16'h0000, ~cn};
            e.f   = full[15:0];
            e.cn4 = ~full[16];
        end
        e.aeqb = &e.f;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("F", 32'(bus.F), 32'(e.f));
                check("Cn4", 32'(bus.Cn4), 32'(e.cn4));
                check("AeqB", 32'(bus.AeqB), 32'(e.aeqb));
            end
        end
    end

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                         input logic m, input logic cn);
        bus.A  = a;
        bus.B  = b;
        bus.S  = s;
        bus.M  = m;
        bus.Cn = cn;
    endtask

    task automatic scramble();
        bus.A  = 16'($urandom);
        bus.B  = 16'($urandom);
        bus.S  = 4'($urandom);
        bus.M  = 1'($urandom);
        bus.Cn = 1'($urandom);
    endtask

    // Called at a negedge; start is sampled at the following posedge.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                          input logic m, input logic cn, input exp_t e, input bit mix);
        int cyc;
        int nbusy;
        bit seen;
        drive(a, b, s, m, cn);
        bus.start = 1'b1;
        sb.push_back(e);
        nbusy = 0;
        seen  = 1'b0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) nbusy++;
            if (mix) scramble();
        end
        check("done_seen", 32'(seen), 32'd1);
        if (seen) check("latency", 32'(cyc), 32'd5);
        else if (sb.size() > 0) void'(sb.pop_back());
        check("busy_cycles", 32'(nbusy), 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int issued;
        int completed;
        int last_t;
        exp_t e;
        logic [15:0] ra;
        logic [15:0] rb;
        logic rcn;

        bus.start = 1'b0;
        drive(16'h0, 16'h0, 4'h0, 1'b0, 1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_F", 32'(bus.F), 32'd0);
        check("rst_Cn4", 32'(bus.Cn4), 32'd1);
        check("rst_AeqB", 32'(bus.AeqB), 32'd0);
        rst = 1'b0;

        run_op(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1, '{f:16'h0100, cn4:1'b1, aeqb:1'b0}, 1'b0);
        run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, '{f:16'h0000, cn4:1'b0, aeqb:1'b0}, 1'b0);
        run_op(16'h0005, 16'h0003, 4'b0110, 1'b0, 1'b0, '{f:16'h0002, cn4:1'b0, aeqb:1'b0}, 1'b0);
        run_op(16'h0007, 16'h0007, 4'b0110, 1'b0, 1'b1, '{f:16'hFFFF, cn4:1'b1, aeqb:1'b1}, 1'b0);
        run_op(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, '{f:16'h0FF0, cn4:1'b1, aeqb:1'b0}, 1'b1);
        check("F_hold_after_done", 32'(bus.F), 32'h0FF0);

        drive(16'h1234, 16'h4321, 4'b1001, 1'b0, 1'b1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("F_hold_in_run", 32'(bus.F), 32'h0FF0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_F", 32'(bus.F), 32'd0);
        check("abort_Cn4", 32'(bus.Cn4), 32'd1);
        check("abort_AeqB", 32'(bus.AeqB), 32'd0);
        rst = 1'b0;
        run_op(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1, '{f:16'h0100, cn4:1'b1, aeqb:1'b0}, 1'b0);

        // Back-to-back sweep over all S/M combinations with start held high.
        issued    = 0;
        completed = 0;
        last_t    = -1;
        ra = 16'($urandom); rb = 16'($urandom); rcn = 1'($urandom);
        drive(ra, rb, 4'(issued), 1'(issued >> 4), rcn);
        sb.push_back(model(ra, rb, 4'(issued), 1'(issued >> 4), rcn));
        issued++;
        bus.start = 1'b1;
        for (int t = 1; t <= 400 && completed < 32; t++) begin
            @(negedge clk);
            if (bus.done) begin
                completed++;
                if (last_t >= 0) check("b2b_period", 32'(t - last_t), 32'd5);
                last_t = t;
                if (issued < 32) begin
                    ra = 16'($urandom); rb = 16'($urandom); rcn = 1'($urandom);
                    drive(ra, rb, 4'(issued), 1'(issued >> 4), rcn);
                    sb.push_back(model(ra, rb, 4'(issued), 1'(issued >> 4), rcn));
                    issued++;
                end else begin
                    bus.start = 1'b0;
                end
            end else if (bus.busy) begin
                scramble();
            end
        end
        bus.start = 1'b0;
        check("b2b_completed", 32'(completed), 32'd32);

        repeat (3) @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("queue_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
